// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic_mm_stream matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sa_state_t;

  // Counter must hold t = 0 .. 3N-2.
  function automatic int cnt_w(input int n);
    return $clog2(3 * n);
  endfunction

  function automatic int full_w(input int data_w, input int n);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: forwards a east / b south, accumulates a*b, sticky overflow.
// Build macro SYSTOLIC_SAT_EN selects a saturating accumulator instead of a wrapping one.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf_out
);

  localparam int P_W = 2 * DATA_W;
  // One spare bit above the wider of product and accumulator catches every carry.
  localparam int S_W = imax(ACC_W, P_W) + 1;

`ifdef SYSTOLIC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [P_W-1:0]    prod;
  logic [S_W-1:0]    sum;
  logic              carry;

  function automatic logic [ACC_W-1:0] acc_next(input logic [ACC_W-1:0] lo, input logic c);
    return (c && SAT_EN) ? {ACC_W{1'b1}} : lo;
  endfunction

  always_comb begin
    prod  = P_W'(a_in) * P_W'(b_in);
    sum   = S_W'(acc_q) + S_W'(prod);
    carry = |sum[S_W-1:ACC_W];
    a_d   = a_in;
    b_d   = b_in;
    acc_d = acc_next(sum[ACC_W-1:0], carry);
    ovf_d = ovf_q | carry;
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign acc_out = acc_q;
  assign ovf_out = ovf_q;

endmodule

// File: rtl/systolic_mm_stream.sv
// Handshaked N x N unsigned matrix multiplier on an output-stationary systolic grid.
// Build macro SYSTOLIC_SAT_EN makes the PE accumulators saturate instead of wrap.
module systolic_mm_stream
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 4,
  parameter int ACC_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  a_in,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]  b_in,
  output logic                             busy,
  output logic                             done,
  output logic [N-1:0][N-1:0][ACC_W-1:0]   c_out,
  output logic                             ovf
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] T_LAST = CW'(3 * N - 2);

  sa_state_t                          state_q;
  logic [CW-1:0]                      cnt_q;
  logic [N-1:0][N-1:0][DATA_W-1:0]    a_q, b_q;
  logic                               busy_q, done_q, ovf_q;
  logic [N-1:0][N-1:0][ACC_W-1:0]     c_q;

  logic                               clr;
  logic [DATA_W-1:0]                  west  [N];
  logic [DATA_W-1:0]                  north [N];
  logic [DATA_W-1:0]                  pe_a  [N][N];
  logic [DATA_W-1:0]                  pe_b  [N][N];
  logic [ACC_W-1:0]                   pe_acc[N][N];
  logic                               pe_ovf[N][N];
  logic [N-1:0][N-1:0][ACC_W-1:0]     acc_all;
  logic                               ovf_any;
  logic                               unused_fwd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // Final cycle only flushes zeros; accumulators are already complete.
          if (cnt_q == T_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            c_q     <= acc_all;
            ovf_q   <= ovf_any;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr = (state_q == LOAD);

  // Row i sees A[i][t-i], column j sees B[t-j][j]; zero outside the window.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      west[i]  = '0;
      north[i] = '0;
      if (state_q == RUN) begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt_q) == i + k) begin
            west[i]  = a_q[i][k];
            north[i] = b_q[k][i];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DATA_W-1:0] a_w, b_w;

      if (j == 0) begin : g_west
        assign a_w = west[i];
      end else begin : g_east
        assign a_w = pe_a[i][j-1];
      end

      if (i == 0) begin : g_north
        assign b_w = north[j];
      end else begin : g_south
        assign b_w = pe_b[i-1][j];
      end

      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .a_in    (a_w),
        .b_in    (b_w),
        .a_out   (pe_a[i][j]),
        .b_out   (pe_b[i][j]),
        .acc_out (pe_acc[i][j]),
        .ovf_out (pe_ovf[i][j])
      );
    end
  end

  always_comb begin
    acc_all    = '0;
    ovf_any    = 1'b0;
    unused_fwd = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_all[i][j] = pe_acc[i][j];
        ovf_any       = ovf_any | pe_ovf[i][j];
      end
      // East edge a and south edge b leave the grid and go nowhere.
      unused_fwd = unused_fwd ^ (^pe_a[i][N-1]) ^ (^pe_b[N-1][i]);
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign c_out = c_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Directed bench for systolic_mm_stream (N=4 main instance plus N=2 / N=8 sweep instances).
module tb_systolic_mm_stream;

  typedef logic [3:0][3:0][3:0] mat_t;
  typedef logic [3:0][3:0][7:0] res_t;

  localparam int AV[16] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15};
  localparam int RS[4]  = '{30, 70, 110, 146};
`ifdef SYSTOLIC_SAT_EN
  localparam logic [7:0] OVF_C = 8'd255;
`else
  localparam logic [7:0] OVF_C = 8'd132;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  mat_t a_in = '0, b_in = '0;
  logic busy, done, ovf;
  res_t c_out;

  logic start2 = 1'b0, busy2, done2, ovf2;
  logic [1:0][1:0][7:0]  a2 = '0, b2 = '0;
  logic [1:0][1:0][18:0] c2;
  logic start8 = 1'b0, busy8, done8, ovf8;
  logic [7:0][7:0][7:0]  a8 = '0, b8 = '0;
  logic [7:0][7:0][18:0] c8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  systolic_mm_stream #(.N(4), .DATA_W(4), .ACC_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .c_out(c_out), .ovf(ovf)
  );

  systolic_mm_stream #(.N(2), .DATA_W(8), .ACC_W(19)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .c_out(c2), .ovf(ovf2)
  );

  systolic_mm_stream #(.N(8), .DATA_W(8), .ACC_W(19)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .c_out(c8), .ovf(ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start with the given operands, scramble the inputs afterwards, wait for done.
  task automatic run_op(input mat_t a, input mat_t b, output int lat, output int bcnt);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    lat   = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    mat_t a_b, b_b, a_id, b_id, a_15, z_m;
    res_t e_basic, e_id, e_ovf;
    int lat, bcnt, cnt, s;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a_b[i][j]     = 4'(AV[i*4+j]);
        b_b[i][j]     = 4'(i + 1);
        a_id[i][j]    = 4'((3 * i + 5 * j + 1) % 16);
        b_id[i][j]    = (i == j) ? 4'd1 : 4'd0;
        a_15[i][j]    = 4'hF;
        z_m[i][j]     = 4'h0;
        e_basic[i][j] = 8'(RS[i]);
        e_id[i][j]    = 8'((3 * i + 5 * j + 1) % 16);
        e_ovf[i][j]   = OVF_C;
      end
    end

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c", c_out, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    run_op(a_b, b_b, lat, bcnt);
    chk("basic_lat", lat, 12);
    chk("basic_busy", bcnt, 12);
    chk("basic_c", c_out, e_basic);
    chk("basic_ovf", ovf, 0);
    tick();
    chk("done_pulse", done, 0);
    chk("c_hold", c_out, e_basic);

    run_op(a_id, b_id, lat, bcnt);
    chk("ident_busy", bcnt, 12);
    chk("ident_c", c_out, e_id);
    run_op(a_b, z_m, lat, bcnt);
    chk("zero_c", c_out, 0);

    run_op(a_15, a_15, lat, bcnt);
    chk("ovf_lat", lat, 12);
    chk("ovf_c", c_out, e_ovf);
    chk("ovf_flag", ovf, 1);
    run_op(a_b, b_b, lat, bcnt);
    chk("ovf_clear", ovf, 0);
    chk("ovf_clear_c", c_out, e_basic);

    // start pulsed during RUN, with operands that would overflow if latched
    a_in = a_b; b_in = b_b; start = 1'b1;
    tick();
    start = 1'b0; a_in = a_15; b_in = a_15; lat = 0;
    repeat (4) begin tick(); lat++; end
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("ign_lat", lat, 12);
    chk("ign_c", c_out, e_basic);
    chk("ign_ovf", ovf, 0);
    cnt = 0;
    repeat (20) begin tick(); if (done || busy) cnt++; end
    chk("ign_idle", cnt, 0);

    // back-to-back with start held; operands change right after each acceptance
    a_in = a_b; b_in = b_b; start = 1'b1;
    tick();
    a_in = a_id; b_in = b_id; lat = 0;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("b2b1_lat", lat, 12);
    chk("b2b1_c", c_out, e_basic);
    lat = 0;
    tick();
    lat++;
    start = 1'b0; a_in = a_15; b_in = a_15;
    chk("b2b_busy", busy, 1);
    chk("b2b_hold", c_out, e_basic);
    while (!done && lat < 40) begin tick(); lat++; end
    chk("b2b2_period", lat, 13);
    chk("b2b2_c", c_out, e_id);

    // reset at RUN t=5 aborts with no done
    run_op(a_15, a_15, lat, bcnt);
    chk("pre_rst_ovf", ovf, 1);
    a_in = a_b; b_in = b_b; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_c", c_out, 0);
    chk("abort_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin tick(); if (done) cnt++; end
    chk("abort_nodone", cnt, 0);
    run_op(a_id, b_id, lat, bcnt);
    chk("post_rst_lat", lat, 12);
    chk("post_rst_c", c_out, e_id);

    // N=2 sweep, first pass at full-scale operands
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          a2[i][j] = (r == 0) ? 8'hFF : 8'($urandom_range(0, 255));
          b2[i][j] = (r == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        end
      end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      lat = 0;
      while (!done2 && lat < 100) begin tick(); lat++; end
      chk("n2_lat", lat, 6);
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 2; j++) begin
          s = 0;
          for (int k = 0; k < 2; k++) s += int'(a2[i][k]) * int'(b2[k][j]);
          chk($sformatf("n2_c%0d%0d", i, j), c2[i][j], s);
        end
      end
      chk("n2_ovf", ovf2, 0);
    end

    // N=8 sweep
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          a8[i][j] = (r == 0) ? 8'hFF : 8'($urandom_range(0, 255));
          b8[i][j] = (r == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        end
      end
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 100) begin tick(); lat++; end
      chk("n8_lat", lat, 24);
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) begin
          s = 0;
          for (int k = 0; k < 8; k++) s += int'(a8[i][k]) * int'(b8[k][j]);
          chk($sformatf("n8_c%0d%0d", i, j), c8[i][j], s);
        end
      end
      chk("n8_ovf", ovf8, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/systolic_mm_stream.md
# systolic_mm_stream

- Parametrised, handshaked N×N unsigned matrix multiplier: C = A·B on an output-stationary systolic grid of N×N multiply-accumulate PEs.
- Unlike the fixed free-running array, it has the following:
  - a start/busy/done handshake;
  - internal row/column skewing of operands latched at start;
  - independent operand and accumulator widths;
  - a registered result that holds between operations;
  - a sticky overflow flag.
- Sits between a matrix source (register file or DMA front end) and any consumer of the product matrix.

## Interface
- `N`, 4, array dimension (matrix is N×N, N ≥ 2).
- `DATA_W`, 4, unsigned operand width.
- `ACC_W`, 8, unsigned accumulator and result width (1 ≤ ACC_W ≤ 2·DATA_W+$clog2(N) is meaningful).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request an operation; sampled only in IDLE or DONE.
- `a_in`  in  [DATA_W-1:0] [N-1:0][N-1:0]  matrix A, element [row][col]; sampled on accepted start only.
- `b_in`  in  [DATA_W-1:0] [N-1:0][N-1:0]  matrix B, same layout and sampling.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle pulse, high in DONE.
- `c_out`  out  [ACC_W-1:0] [N-1:0][N-1:0]  result matrix; updates only on the edge entering DONE.
- `ovf`  out  1  overflow of any accumulator in the last completed operation; updates with c_out.

## Operation
- FSM states: IDLE → LOAD → RUN → DONE → IDLE.
  - IDLE: start=1 latches a_in/b_in into operand registers and moves to LOAD.
  - LOAD (1 cycle): clears all accumulators, PE pipeline registers and the internal overflow flags; sets cycle counter t=0.
  - RUN (3N−1 cycles, t = 0..3N−2):
    - west edge of row i receives A[i][t−i] when 0 ≤ t−i < N, else 0;
    - north edge of column j receives B[t−j][j] when 0 ≤ t−j < N, else 0;
    - each PE multiplies its registered a and b inputs, accumulates, and forwards a east and b south with one register each;
    - last cycle (t=3N−2) is a flush cycle.
  - DONE (1 cycle): done=1. start=1 here is accepted exactly as in IDLE (→ LOAD); otherwise → IDLE.
- start while busy is ignored. a_in/b_in may change freely after acceptance.
- Arithmetic: products are 2·DATA_W bits, zero-extended into the accumulator. Per-PE overflow flag is set when an add carries out of ACC_W bits.
- On entry to DONE: c_out ← accumulators, ovf ← OR of all PE overflow flags.

## Timing
- Reset values: state IDLE, busy=0, done=0, c_out all 0, ovf=0, all internal registers 0.
- Reset mid-operation aborts immediately; no done follows.
- If start is sampled at edge k: LOAD after k, RUN after k+1, DONE after k+3N, done visible for the single cycle after edge k+3N. For N=4 that is 12 edges.
- Back-to-back: start held high gives one result every 3N+1 cycles.
- c_out and ovf are stable from edge k+3N until the next DONE entry or reset.

## Configuration
- `SYSTOLIC_SAT_EN` defined: each accumulator clamps at 2^ACC_W−1 on overflow and stays clamped for the rest of the operation.
- `SYSTOLIC_SAT_EN` undefined: accumulators wrap modulo 2^ACC_W.
- ovf is reported identically in both builds.

## Structure
- Package `systolic_pkg`:
  - state enum `sa_state_t` (IDLE, LOAD, RUN, DONE);
  - localparam function for counter width ($clog2(3N));
  - helper for the full-precision width 2·DATA_W+$clog2(N).
- Sub-module `systolic_pe`:
  - one MAC cell with a/b forwarding registers, clear input, accumulator and sticky overflow bit;
  - saturation under `SYSTOLIC_SAT_EN`;
  - instantiated N×N by generate.
- Top module holds the FSM, counter, operand registers, skew muxing and output registers.

## Test plan
- Basic product, N=4, DATA_W=4, ACC_W=8:
  - A rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,15}; B row k all (k+1).
  - Required: every row of C equals 30/70/110/146 across all columns, ovf=0, done exactly 12 edges after start.
- Identity: B=I, A arbitrary → C=A. Then B=0 → C all 0. busy high for exactly LOAD+RUN (3N cycles).
- Overflow: A and B all 15 (true sum 900).
  - Without `SYSTOLIC_SAT_EN`: C all 132, ovf=1.
  - With `SYSTOLIC_SAT_EN`: C all 255, ovf=1.
  - A following benign operation clears ovf to 0.
- Handshake: start pulsed during RUN is ignored. start held high gives results every 13 cycles, and each c_out matches its own latched operands even though a_in/b_in change after acceptance.
- Reset: rst asserted at RUN t=5 → immediately busy=0, done=0, c_out=0, ovf=0, no done pulse. A new start after release produces the correct result.
- Parameter sweep: N=2 and N=8 with DATA_W=8, ACC_W=19 against random operands. c_out must equal a reference model, with done at 3N edges.
